// File: rtl/conv_encoder_frame.sv
// conv_encoder_frame
//   Frame-based rate-1/2, K=3 convolutional encoder (G1=7, G0=5).
//   An accepted i_start latches DATA_W payload bits, which are then encoded
//   LSB first at one coded symbol per cycle.
//
//   Optional feature macro: CONV_ENC_TAIL_EN
//     defined   -> two zero tail bits flush the encoder (DATA_W+2 symbols)
//     undefined -> DATA_W symbols, final encoder state left unflushed
//
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   i_start  frame request, honoured only in IDLE
//   i_data   payload, captured with an accepted i_start
//   o_code   coded symbol {c1,c0}; 00 when o_valid=0
//   o_valid  symbol present this cycle (ENC/TAIL)
//   o_busy   frame in progress (ENC/TAIL/DONE)
//   o_done   one-cycle pulse after the last symbol
module conv_encoder_frame #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    output logic [1:0]        o_code,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done
);

    // Wide enough for DATA_W+2 without wrapping.
    localparam int CW = $clog2(DATA_W + 3);
    localparam logic [CW-1:0] CNT_DATA_LAST = CW'(DATA_W - 1);
`ifdef CONV_ENC_TAIL_EN
    localparam logic [CW-1:0] CNT_TAIL_LAST = CW'(DATA_W + 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;    // payload, bit 0 is the next input bit
    logic [1:0]        enc_q, enc_d;  // {s1,s0}: s1 = previous bit, s0 = one before
    logic [CW-1:0]     cnt_q, cnt_d;  // symbols already emitted in this frame
    logic              u;             // encoder input bit this cycle

    // Tail bits are zero, so only ENC takes its input from the payload.
    assign u = (state_q == ENC) ? sr_q[0] : 1'b0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            enc_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            enc_q   <= enc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        enc_d   = enc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = ENC;
                    sr_d    = i_data;
                    enc_d   = 2'b00;
                    cnt_d   = '0;
                end
            end
            ENC: begin
                sr_d  = sr_q >> 1;
                enc_d = {u, enc_q[1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_DATA_LAST) begin
`ifdef CONV_ENC_TAIL_EN
                    state_d = TAIL;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CONV_ENC_TAIL_EN
            TAIL: begin
                enc_d = {1'b0, enc_q[1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_TAIL_LAST) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_code  = 2'b00;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ENC, TAIL: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                o_code  = {u ^ enc_q[1] ^ enc_q[0], u ^ enc_q[0]};
            end
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
